// File: rtl/timer_down32.sv
// rtl/timer_down32.sv - loadable 32-bit down-counting timer with one-shot and periodic modes
//
// Purpose:
//   Software loads a count, starts the timer and gets a one-cycle expired
//   pulse plus a sticky irq flag when the count runs out. Periodic mode
//   reloads the count on expiry and keeps running; one-shot mode parks in
//   DONE with count=0 until restarted or reloaded.
//
// Ports:
//   clk            system clock, all state updates on posedge
//   rst            asynchronous active-low reset
//   load_valid     load request
//   load_ready     high whenever the timer is not running
//   load_value     initial count, also the reload value
//   load_periodic  1 = auto-reload, 0 = one-shot
//   start          begin/resume counting (ARMED or DONE)
//   stop           pause counting (RUN only); wins over start
//   irq_ack        clears irq (an expiry in the same cycle wins)
//   count          current count value
//   running        registered decode of state==RUN
//   expired        one-cycle registered pulse per expiry
//   irq            sticky expiry flag
//
// Configuration:
//   TIMER_DOWN32_PRESCALE_EN  when defined, a prescale counter makes the
//   count decrement once every PRESCALE+1 RUN cycles. When undefined every
//   RUN cycle is a tick and PRESCALE has no effect.

module timer_down32 #(
  parameter int unsigned PRESCALE = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_value,
  input  logic        load_periodic,
  input  logic        start,
  input  logic        stop,
  input  logic        irq_ack,
  output logic [31:0] count,
  output logic        running,
  output logic        expired,
  output logic        irq
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] count_q, count_d;
  logic [31:0] reload_q, reload_d;
  logic        periodic_q, periodic_d;
  logic        running_q;
  logic        expired_q, expired_d;
  logic        irq_q, irq_d;

  logic        load_acc;
  logic        start_eff;
  logic        tick;
  logic        expiry;

`ifdef TIMER_DOWN32_PRESCALE_EN
  logic [31:0] ps_q, ps_d;
`else
  logic        prescale_unused;
  assign prescale_unused = (PRESCALE == 0);
`endif

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output / control decode
  // ---------------------------------------------------------------------
  always_comb begin
    load_ready = (state_q != S_RUN);
    load_acc   = load_valid && (state_q != S_RUN);
    // stop beats start in the same cycle
    start_eff  = start && !stop;
`ifdef TIMER_DOWN32_PRESCALE_EN
    tick       = (state_q == S_RUN) && (ps_q == PRESCALE);
`else
    tick       = (state_q == S_RUN);
`endif
    expiry     = tick && (count_q == 32'd1);
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (load_acc) begin
      // a load always wins over a simultaneous start
      state_d = (load_value == 32'd0) ? S_IDLE : S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: if (start_eff) state_d = S_RUN;
        S_DONE:  if (start_eff) state_d = S_RUN;
        S_RUN: begin
          // A one-shot expiry completes even if stop arrives on the same
          // edge; otherwise stop pauses the timer.
          if (expiry && !periodic_q) begin
            state_d = S_DONE;
          end else if (stop) begin
            state_d = S_ARMED;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Datapath next values
  // ---------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    reload_d   = reload_q;
    periodic_d = periodic_q;

    if (load_acc) begin
      count_d    = load_value;
      reload_d   = load_value;
      periodic_d = load_periodic;
    end else if ((state_q == S_DONE) && start_eff) begin
      count_d = reload_q;
    end else if (tick) begin
      // A tick taken on the same edge as stop still counts.
      if (expiry) begin
        count_d = periodic_q ? reload_q : 32'd0;
      end else if (count_q != 32'd0) begin
        count_d = count_q - 32'd1;
      end
    end

    expired_d = expiry;
    // set has priority over acknowledge
    irq_d     = expiry || (irq_q && !irq_ack);
  end

`ifdef TIMER_DOWN32_PRESCALE_EN
  // The prescaler only advances while RUN continues; entering RUN or
  // leaving it (stop, expiry into DONE) restarts the phase at 0.
  always_comb begin
    ps_d = 32'd0;
    if ((state_q == S_RUN) && (state_d == S_RUN)) begin
      ps_d = (ps_q == PRESCALE) ? 32'd0 : ps_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ps_q <= 32'd0;
    end else begin
      ps_q <= ps_d;
    end
  end
`endif

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q    <= 32'd0;
      reload_q   <= 32'd0;
      periodic_q <= 1'b0;
      running_q  <= 1'b0;
      expired_q  <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      reload_q   <= reload_d;
      periodic_q <= periodic_d;
      running_q  <= (state_d == S_RUN);
      expired_q  <= expired_d;
      irq_q      <= irq_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign expired = expired_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_timer_down32.sv
// tb/tb_timer_down32.sv - self-checking bench for timer_down32
module tb_timer_down32;

  logic        clk;
  logic        rst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_value;
  logic        load_periodic;
  logic        start;
  logic        stop;
  logic        irq_ack;
  logic [31:0] count;
  logic        running;
  logic        expired;
  logic        irq;

  int errors = 0;
  int checks = 0;

  timer_down32 #(
    .PRESCALE(3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .load_valid    (load_valid),
    .load_ready    (load_ready),
    .load_value    (load_value),
    .load_periodic (load_periodic),
    .start         (start),
    .stop          (stop),
    .irq_ack       (irq_ack),
    .count         (count),
    .running       (running),
    .expired       (expired),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        lv;
    logic [31:0] val;
    logic        per;
    logic        st;
    logic        sp;
    logic        ack;
    logic [31:0] e_count;
    logic        e_run;
    logic        e_exp;
    logic        e_irq;
    logic        e_rdy;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic lv, input logic [31:0] val, input logic per,
                     input logic st, input logic sp, input logic ack,
                     input logic [31:0] ec, input logic er, input logic ee,
                     input logic ei, input logic erdy);
    vec_t v;
    v.lv = lv; v.val = val; v.per = per; v.st = st; v.sp = sp; v.ack = ack;
    v.e_count = ec; v.e_run = er; v.e_exp = ee; v.e_irq = ei; v.e_rdy = erdy;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_valid = 1'b0; load_value = 32'd0; load_periodic = 1'b0;
    start = 1'b0; stop = 1'b0; irq_ack = 1'b0;
  endtask

  initial begin
    int seen;
    rst = 1'b0;
    idle_inputs();
    step();
    step();
    check("reset_count", count, 32'd0);
    check("reset_running", {31'd0, running}, 32'd0);
    check("reset_expired", {31'd0, expired}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_ready", {31'd0, load_ready}, 32'd1);
    rst = 1'b1;
    step();

`ifndef TIMER_DOWN32_PRESCALE_EN
    // lv val per st sp ack | count run exp irq rdy
    add(1, 5, 0, 0, 0, 0,   5, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0,   5, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   4, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
    add(1, 3, 1, 0, 0, 0,   3, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0,   3, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   3, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 0,   2, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,   3, 1, 1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   3, 1, 1, 1, 0);
    add(0, 0, 0, 0, 1, 0,   2, 0, 0, 1, 1);
    add(0, 0, 0, 1, 1, 0,   2, 0, 0, 1, 1);
    add(1, 4, 0, 1, 0, 0,   4, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0,   4, 0, 0, 1, 1);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 1, 1);
    add(0, 0, 0, 1, 0, 0,   0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);
    add(1, 2, 0, 0, 0, 0,   2, 0, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0,   2, 1, 0, 0, 0);
    add(1, 9, 1, 0, 0, 0,   1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0,   0, 0, 1, 1, 1);
    add(0, 0, 0, 1, 0, 0,   2, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0,   1, 1, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,   0, 0, 1, 1, 1);
    add(0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 1);

    foreach (vecs[i]) begin
      load_valid = vecs[i].lv; load_value = vecs[i].val; load_periodic = vecs[i].per;
      start = vecs[i].st; stop = vecs[i].sp; irq_ack = vecs[i].ack;
      step();
      check($sformatf("v%0d_count", i), count, vecs[i].e_count);
      check($sformatf("v%0d_running", i), {31'd0, running}, {31'd0, vecs[i].e_run});
      check($sformatf("v%0d_expired", i), {31'd0, expired}, {31'd0, vecs[i].e_exp});
      check($sformatf("v%0d_irq", i), {31'd0, irq}, {31'd0, vecs[i].e_irq});
      check($sformatf("v%0d_ready", i), {31'd0, load_ready}, {31'd0, vecs[i].e_rdy});
    end
    idle_inputs();

    // Stop at the tick that produces 6, hold, then restart to expiry.
    load_valid = 1'b1; load_value = 32'd10; step(); idle_inputs();
    start = 1'b1; step(); start = 1'b0;
    check("stop_first", count, 32'd10);
    step(); step(); step();
    check("stop_pre", count, 32'd7);
    stop = 1'b1; step(); stop = 1'b0;
    check("stop_count", count, 32'd6);
    check("stop_running", {31'd0, running}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("hold%0d_count", k), count, 32'd6);
      check($sformatf("hold%0d_ready", k), {31'd0, load_ready}, 32'd1);
    end
    start = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step();
      start = 1'b0;
      check($sformatf("restart%0d_expired", k), {31'd0, expired}, (k == 7) ? 32'd1 : 32'd0);
      check($sformatf("restart%0d_count", k), count, (k == 7) ? 32'd0 : 32'(7 - k));
    end
    irq_ack = 1'b1; step(); irq_ack = 1'b0;

    // Asynchronous reset in the middle of a run.
    load_valid = 1'b1; load_value = 32'd10; step(); idle_inputs();
    start = 1'b1; step(); start = 1'b0;
    seen = 0;
    for (int k = 0; k < 20 && seen == 0; k++) begin
      if (count == 32'd7) seen = 1;
      else step();
    end
    check("rst_reach7", seen, 1);
    rst = 1'b0;
    #1;
    check("rst_count", count, 32'd0);
    check("rst_running", {31'd0, running}, 32'd0);
    check("rst_expired", {31'd0, expired}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    check("rst_ready", {31'd0, load_ready}, 32'd1);
    step();
    rst = 1'b1;
    step();
    check("post_rst_count", count, 32'd0);
    check("post_rst_running", {31'd0, running}, 32'd0);
`else
    // PRESCALE=3, load 2: expiry seen 9 cycles after start.
    load_valid = 1'b1; load_value = 32'd2; step(); idle_inputs();
    start = 1'b1;
    seen = 0;
    for (int k = 1; k <= 20 && seen == 0; k++) begin
      step();
      start = 1'b0;
      if (expired) seen = k;
    end
    check("ps_latency", seen, 9);
    check("ps_count", count, 32'd0);
    check("ps_irq", {31'd0, irq}, 32'd1);
    check("ps_running", {31'd0, running}, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
